// File: rtl/fir_ctrl_pkg.sv
// Shared types and width helpers for the FIR coefficient reload path.
// Also used by fir_filter to size its coefficient bank/address ports.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    DRAIN     = 2'd2,
    WAIT_SWAP = 2'd3
  } coef_state_t;

  // A single-entry RAM still needs a one-bit address port.
  function automatic int addr_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fir_frame_tracker.sv
// Follows a valid/last stream and reports whether a frame is open and
// whether the current cycle closes one.
module fir_frame_tracker (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_data_tvalid,
  input  logic i_data_tlast,
  output logic o_frame_active,
  output logic o_boundary
);

  logic r_frame_active;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_active <= 1'b0;
    end else if (i_data_tvalid) begin
      r_frame_active <= !i_data_tlast;
    end
  end

  assign o_frame_active = r_frame_active;
  assign o_boundary     = i_data_tvalid & i_data_tlast;

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient reload controller: writes a config-stream frame into the FIR's
// shadow bank and flips the active bank only between data frames.
module fir_coef_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter  int TAP_LENGTH = 28,
  parameter  int COEF_BW    = 16,
  localparam int ADDR_W     = addr_w(TAP_LENGTH)
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_aresetn,
  input  logic [COEF_BW-1:0] s_axis_coef_tdata,
  input  logic               s_axis_coef_tvalid,
  input  logic               s_axis_coef_tlast,
  output logic               s_axis_coef_tready,
  input  logic               data_tvalid,
  input  logic               data_tlast,
  output logic               coef_wr_en,
  output logic               coef_wr_bank,
  output logic [ADDR_W-1:0]  coef_wr_addr,
  output logic [COEF_BW-1:0] coef_wr_data,
  output logic               coef_bank_sel,
  output logic               load_done,
  output logic               load_err,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAP_LENGTH - 1);

  coef_state_t        r_state;
  coef_state_t        w_state_nxt;
  logic [ADDR_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0]  w_idx;
  logic               r_tready;
  logic               r_swap_arm;
  logic               r_bank_sel;
  logic               w_bank_sel_nxt;
  logic               r_wr_en;
  logic               r_wr_bank;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [COEF_BW-1:0] r_wr_data;
  logic               r_load_done;
  logic               r_load_err;
  logic               w_wr_en_nxt;
  logic               w_load_err_nxt;
  logic               w_accept;
  logic               w_at_last;
  logic               w_frame_active;
  logic               w_boundary;
  logic               w_swap_ok;
  logic               w_swap;

  fir_frame_tracker u_frame_tracker (
    .i_clk          (s_axis_aclk),
    .i_rst_n        (s_axis_aresetn),
    .i_data_tvalid  (data_tvalid),
    .i_data_tlast   (data_tlast),
    .o_frame_active (w_frame_active),
    .o_boundary     (w_boundary)
  );

  // Config handshake: a beat transfers on any rising edge where tvalid and
  // tready are both high; tready is a register and never depends on tvalid.
  assign w_accept  = s_axis_coef_tvalid & r_tready;
  assign w_idx     = (r_state == IDLE) ? '0 : r_cnt;
  assign w_at_last = (w_idx == LAST_IDX);

  // Safe point: a data frame ends now, or the stream is quiet between frames.
  // The first WAIT_SWAP cycle is skipped so a coincident data tlast cannot swap.
  assign w_swap_ok      = w_boundary | (!w_frame_active & !data_tvalid);
  assign w_swap         = (r_state == WAIT_SWAP) & r_swap_arm & w_swap_ok;
  assign w_bank_sel_nxt = r_bank_sel ^ w_swap;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, LOAD: begin
        if (w_accept) begin
          if (s_axis_coef_tlast) begin
            w_state_nxt = w_at_last ? WAIT_SWAP : IDLE;
          end else begin
            w_state_nxt = w_at_last ? DRAIN : LOAD;
          end
        end
      end
      DRAIN: begin
        if (w_accept && s_axis_coef_tlast) begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_SWAP: begin
        if (w_swap) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wr_en_nxt    = 1'b0;
    w_load_err_nxt = 1'b0;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      IDLE, LOAD: begin
        if (w_accept) begin
          w_wr_en_nxt    = 1'b1;
          w_cnt_nxt      = w_idx + ADDR_W'(1);
          w_load_err_nxt = s_axis_coef_tlast && !w_at_last;
        end
      end
      DRAIN: begin
        w_load_err_nxt = w_accept && s_axis_coef_tlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_cnt       <= '0;
      r_tready    <= 1'b0;
      r_swap_arm  <= 1'b0;
      r_bank_sel  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_bank   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_tready    <= (w_state_nxt != WAIT_SWAP);
      r_swap_arm  <= (r_state == WAIT_SWAP);
      r_bank_sel  <= w_bank_sel_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_bank   <= ~w_bank_sel_nxt;
      r_load_done <= w_swap;
      r_load_err  <= w_load_err_nxt;
      if (w_wr_en_nxt) begin
        r_wr_addr <= w_idx;
        r_wr_data <= s_axis_coef_tdata;
      end
    end
  end

  assign s_axis_coef_tready = r_tready;
  assign coef_wr_en         = r_wr_en;
  assign coef_wr_bank       = r_wr_bank;
  assign coef_wr_addr       = r_wr_addr;
  assign coef_wr_data       = r_wr_data;
  assign coef_bank_sel      = r_bank_sel;
  assign load_done          = r_load_done;
  assign load_err           = r_load_err;
  assign busy               = (r_state != IDLE);
  assign dbg_state          = r_state;

  a_pulse_excl : assert property (@(posedge s_axis_aclk) disable iff (!s_axis_aresetn)
    !(r_load_done && r_load_err));
  a_done_single : assert property (@(posedge s_axis_aclk) disable iff (!s_axis_aresetn)
    r_load_done |=> !r_load_done);
  a_wait_not_ready : assert property (@(posedge s_axis_aclk) disable iff (!s_axis_aresetn)
    (r_state == WAIT_SWAP) |-> !r_tready);

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Bench for fir_coef_ctrl: frame-level reference model, per-cycle compare,
// write scoreboard, directed scenarios and randomized traffic.
module tb_fir_coef_ctrl;

  localparam int T  = 28;
  localparam int CB = 16;
  localparam int AW = 5;
  localparam int W  = 1 + AW + CB;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [CB-1:0] s_axis_coef_tdata  = '0;
  logic          s_axis_coef_tvalid = 1'b0;
  logic          s_axis_coef_tlast  = 1'b0;
  logic          s_axis_coef_tready;
  logic          data_tvalid = 1'b0;
  logic          data_tlast  = 1'b0;
  logic          coef_wr_en;
  logic          coef_wr_bank;
  logic [AW-1:0] coef_wr_addr;
  logic [CB-1:0] coef_wr_data;
  logic          coef_bank_sel;
  logic          load_done;
  logic          load_err;
  logic          busy;
  logic [1:0]    dbg_state;

  fir_coef_ctrl #(.TAP_LENGTH(T), .COEF_BW(CB)) dut (
    .s_axis_aclk        (clk),
    .s_axis_aresetn     (rst_n),
    .s_axis_coef_tdata  (s_axis_coef_tdata),
    .s_axis_coef_tvalid (s_axis_coef_tvalid),
    .s_axis_coef_tlast  (s_axis_coef_tlast),
    .s_axis_coef_tready (s_axis_coef_tready),
    .data_tvalid        (data_tvalid),
    .data_tlast         (data_tlast),
    .coef_wr_en         (coef_wr_en),
    .coef_wr_bank       (coef_wr_bank),
    .coef_wr_addr       (coef_wr_addr),
    .coef_wr_data       (coef_wr_data),
    .coef_bank_sel      (coef_bank_sel),
    .load_done          (load_done),
    .load_err           (load_err),
    .busy               (busy),
    .dbg_state          (dbg_state)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Counts beats of the current config frame; a frame of exactly T beats
  // becomes a pending swap, which fires at the first safe point from the
  // second waiting cycle on.
  bit m_tready, m_bank, m_pend, m_fa, m_acc, m_safe;
  int m_nbeats = 0;
  int m_age    = 0;
  bit e_done, e_err, e_wr_en, e_busy;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tready = 1'b0; m_bank = 1'b0; m_pend = 1'b0; m_fa = 1'b0;
      m_nbeats = 0; m_age = 0;
      e_done = 1'b0; e_err = 1'b0; e_wr_en = 1'b0; e_busy = 1'b0;
      exp_q.delete();
    end else begin
      m_acc   = s_axis_coef_tvalid && m_tready;
      m_safe  = (data_tvalid && data_tlast) || (!m_fa && !data_tvalid);
      e_done  = 1'b0;
      e_err   = 1'b0;
      e_wr_en = 1'b0;
      if (m_pend) begin
        if (m_age >= 1 && m_safe) begin
          m_bank = !m_bank;
          e_done = 1'b1;
          m_pend = 1'b0;
        end
        m_age++;
      end else if (m_acc) begin
        if (m_nbeats < T) begin
          e_wr_en = 1'b1;
          exp_q.push_back({!m_bank, AW'(m_nbeats), s_axis_coef_tdata});
        end
        m_nbeats++;
        if (s_axis_coef_tlast) begin
          if (m_nbeats == T) begin
            m_pend = 1'b1;
            m_age  = 0;
          end else begin
            e_err = 1'b1;
          end
          m_nbeats = 0;
        end
      end
      if (data_tvalid) m_fa = !data_tlast;
      m_tready = !m_pend;
      e_busy   = m_pend || (m_nbeats > 0);
    end
  end

  // ---------------- compare + scoreboard ----------------
  int n_wr, n_wr_b1, sum_addr, sum_data, n_done, n_errp, n_rdy_low, done_edge;
  logic [W-1:0] sb_e;

  always @(negedge clk) begin
    chk("ctl", {s_axis_coef_tready, coef_bank_sel, busy, load_done, load_err, coef_wr_en, dbg_state == 2'd0},
               {m_tready, m_bank, e_busy, e_done, e_err, e_wr_en, !e_busy});
    if (coef_wr_en) begin
      chk("wr_q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        chk("wr_word", {coef_wr_bank, coef_wr_addr, coef_wr_data}, sb_e);
      end
      n_wr++;
      n_wr_b1  += int'(coef_wr_bank);
      sum_addr += int'(coef_wr_addr);
      sum_data += int'(coef_wr_data);
    end
    if (load_done) begin
      n_done++;
      done_edge = cyc;
    end
    if (load_err) n_errp++;
    if (!s_axis_coef_tready) n_rdy_low++;
  end

  task automatic clear_counts();
    n_wr = 0; n_wr_b1 = 0; sum_addr = 0; sum_data = 0;
    n_done = 0; n_errp = 0; n_rdy_low = 0; done_edge = -1;
  endtask

  // ---------------- driver ----------------
  int last_edge  = -1;
  int dlast_edge = -1;

  task automatic run(input int clen, cstart, dlen, dframes, dstart, ncyc, cgap, dgap,
                     input bit seqv);
    int ck, dk;
    bit hold, cacc, dacc;
    ck = 0; dk = 0; hold = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (!hold) begin
        if (c >= cstart && ck < clen && $urandom_range(99) >= cgap) begin
          s_axis_coef_tvalid = 1'b1;
          s_axis_coef_tdata  = seqv ? CB'(ck + 1) : CB'($urandom);
          s_axis_coef_tlast  = (ck == clen - 1);
        end else begin
          s_axis_coef_tvalid = 1'b0;
          s_axis_coef_tdata  = CB'($urandom);
          s_axis_coef_tlast  = 1'($urandom_range(1));
        end
      end
      if (c >= dstart && dk < dlen * dframes && $urandom_range(99) >= dgap) begin
        data_tvalid = 1'b1;
        data_tlast  = (dk % dlen == dlen - 1);
      end else begin
        data_tvalid = 1'b0;
        data_tlast  = 1'($urandom_range(1));
      end
      cacc = s_axis_coef_tvalid && s_axis_coef_tready;
      hold = s_axis_coef_tvalid && !s_axis_coef_tready;
      dacc = data_tvalid;
      @(posedge clk); #1;
      if (cacc) begin
        ck++;
        if (s_axis_coef_tlast) last_edge = cyc;
      end
      if (dacc) begin
        if (data_tlast) dlast_edge = cyc;
        dk++;
      end
    end
    s_axis_coef_tvalid = 1'b0;
    s_axis_coef_tlast  = 1'b0;
    data_tvalid        = 1'b0;
    data_tlast         = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int r_clen, r_dlen, r_dfr, r_ncyc;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {s_axis_coef_tready, coef_wr_en, coef_wr_bank, coef_wr_addr, coef_wr_data,
                          coef_bank_sel, load_done, load_err, busy, dbg_state}, 0);
    rst_n = 1'b1;
    chk("ready_before_first_edge", s_axis_coef_tready, 0);
    @(posedge clk); #1;
    chk("ready_after_first_edge", s_axis_coef_tready, 1);

    // Idle data stream, values 1..28
    clear_counts();
    run(28, 0, 1, 0, 0, 36, 0, 0, 1'b1);
    chk("t1_nwr", n_wr, 28);
    chk("t1_sum_addr", sum_addr, 378);
    chk("t1_sum_data", sum_data, 406);
    chk("t1_bank1_writes", n_wr_b1, 28);
    chk("t1_ndone", n_done, 1);
    chk("t1_latency", done_edge - last_edge, 2);
    chk("t1_ready_low", n_rdy_low, 2);
    chk("t1_bank_sel", coef_bank_sel, 1);
    chk("t1_nerr", n_errp, 0);

    // Coef frame ends at data beat 10 of a 64-beat frame
    clear_counts();
    run(28, 2, 64, 1, 20, 100, 0, 0, 1'b0);
    chk("t2_ndone", n_done, 1);
    chk("t2_swap_at_data_tlast", done_edge, dlast_edge);
    chk("t2_wait_len", done_edge - last_edge, 54);
    chk("t2_bank_sel", coef_bank_sel, 0);

    // Short frame, then a normal one
    clear_counts();
    run(5, 0, 1, 0, 0, 10, 0, 0, 1'b0);
    chk("t3_nerr", n_errp, 1);
    chk("t3_ndone", n_done, 0);
    chk("t3_nwr", n_wr, 5);
    chk("t3_bank_sel", coef_bank_sel, 0);
    clear_counts();
    run(28, 0, 1, 0, 0, 36, 0, 0, 1'b0);
    chk("t3b_ndone", n_done, 1);
    chk("t3b_nerr", n_errp, 0);
    chk("t3b_bank_sel", coef_bank_sel, 1);

    // Long frame of 31 beats
    clear_counts();
    run(31, 0, 1, 0, 0, 40, 0, 0, 1'b1);
    chk("t4_nwr", n_wr, 28);
    chk("t4_sum_addr", sum_addr, 378);
    chk("t4_nerr", n_errp, 1);
    chk("t4_ndone", n_done, 0);
    chk("t4_bank_sel", coef_bank_sel, 1);

    // Coef tlast coincides with data tlast, next data frame starts at once
    clear_counts();
    run(28, 0, 10, 2, 18, 50, 0, 0, 1'b0);
    chk("t5_ndone", n_done, 1);
    chk("t5_swap_delay", done_edge - last_edge, 10);
    chk("t5_bank_sel", coef_bank_sel, 0);

    // Reset while waiting to swap, after a prior swap
    clear_counts();
    run(28, 0, 1, 0, 0, 36, 0, 0, 1'b0);
    chk("t6_prior_bank", coef_bank_sel, 1);
    run(28, 0, 200, 1, 0, 40, 0, 0, 1'b0);
    chk("t6_waiting_busy", busy, 1);
    chk("t6_waiting_ready", s_axis_coef_tready, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {s_axis_coef_tready, coef_wr_en, coef_wr_bank, coef_wr_addr, coef_wr_data,
                             coef_bank_sel, load_done, load_err, busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t6_ready_pre_edge", s_axis_coef_tready, 0);
    @(posedge clk); #1;
    chk("t6_ready_post_edge", s_axis_coef_tready, 1);
    chk("t6_bank_after_reset", coef_bank_sel, 0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      r_clen = ($urandom_range(1) == 1) ? T : int'($urandom_range(34, 1));
      r_dlen = int'($urandom_range(40, 1));
      r_dfr  = int'($urandom_range(3, 0));
      r_ncyc = 10 + r_clen * 3 + r_dlen * r_dfr * 3;
      run(r_clen, int'($urandom_range(10)), r_dlen, r_dfr, int'($urandom_range(30)), r_ncyc,
          int'($urandom_range(50)), int'($urandom_range(50)), 1'b0);
      if ($urandom_range(19) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end
    repeat (20) @(posedge clk);
    #1;
    chk("final_exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
Run-time coefficient reload controller for fir_filter. Accepts a coefficient frame on an AXI4-Stream config port and writes it into the FIR's inactive (shadow) coefficient bank. Swaps the active bank only at a data-frame boundary on the FIR input stream, so no output sample is computed with mixed coefficients. Sits beside fir_filter and shares its clock and reset.

Parameters:
TAP_LENGTH, 28, unique (symmetric-folded) coefficient count per bank
COEF_BW, 16, coefficient width, signed two's complement
ADDR_W, $clog2(TAP_LENGTH), coefficient address width (derived, not overridden)

Ports:
s_axis_aclk  in  1  clock
s_axis_aresetn  in  1  asynchronous active-low reset
s_axis_coef_tdata  in  COEF_BW  coefficient beat; beat k = coef index k
s_axis_coef_tvalid  in  1  coefficient beat valid
s_axis_coef_tlast  in  1  last beat of a coefficient frame
s_axis_coef_tready  out  1  controller accepts beat
data_tvalid  in  1  tap of FIR s_axis_tvalid (monitor only)
data_tlast  in  1  tap of FIR s_axis_tlast (monitor only)
coef_wr_en  out  1  write strobe to FIR coefficient RAM
coef_wr_bank  out  1  bank written (always ~coef_bank_sel)
coef_wr_addr  out  ADDR_W  write address
coef_wr_data  out  COEF_BW  write data
coef_bank_sel  out  1  bank used by FIR datapath
load_done  out  1  one-cycle pulse: swap performed
load_err  out  1  one-cycle pulse: malformed frame discarded
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, s_axis_aclk. Reset s_axis_aresetn is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - All outputs 0, including tready, coef_bank_sel and all pulses.
  - tready is registered. It goes to 1 on the first clock edge after reset deasserts.
- A beat is accepted when tvalid & tready.
- Write port timing: registered, one cycle after acceptance.
  - coef_wr_en = 1 at addr = beat count, data = tdata, bank = ~coef_bank_sel.
- Frame tracker:
  - frame_active is set on data_tvalid & !data_tlast.
  - It is cleared on data_tvalid & data_tlast.
  - Reset value 0.
- IDLE (tready = 1):
  - First accepted beat: write addr 0, cnt <= 1, go to LOAD.
  - If that beat has tlast and TAP_LENGTH > 1: load_err, stay in IDLE.
- LOAD (tready = 1):
  - Each accepted beat writes addr cnt, then cnt++.
  - tlast with cnt == TAP_LENGTH-1: go to WAIT_SWAP; tready <= 0 on the same edge.
  - tlast with cnt < TAP_LENGTH-1: load_err pulse, go to IDLE. Shadow bank contents are undefined; the active bank is untouched.
  - cnt == TAP_LENGTH-1 without tlast: write the beat, go to DRAIN.
- DRAIN (tready = 1):
  - Discard beats with no writes until tlast.
  - On tlast: load_err pulse, go to IDLE.
- WAIT_SWAP (tready = 0):
  - The swap condition is (data_tvalid & data_tlast) | (!frame_active & !data_tvalid).
  - It is evaluated from the cycle after entry. A data tlast coincident with the coef tlast does not trigger the swap.
  - On the condition: coef_bank_sel toggles on that edge and is effective for the next data beat. load_done pulses the same cycle. Go to IDLE; tready <= 1.
- coef_bank_sel changes only in WAIT_SWAP. At most one toggle per loaded frame.
- Reset mid-operation: return to reset values. coef_bank_sel returns to 0, so the loader (software) must reload both banks.
- load_done and load_err are never high together and are never high for more than one cycle.
- Latency, last coef beat to swap:
  - 2 cycles minimum when the data stream is idle.
  - Otherwise bounded by the end of the current data frame.

Decomposition:
- fir_ctrl_pkg:
  - state enum coef_state_t {IDLE, LOAD, DRAIN, WAIT_SWAP}.
  - Function addr_w(n) returning $clog2(n), or 1 if n == 1.
  - Shared with fir_filter for bank/address widths.
- One natural sub-module: fir_frame_tracker, which takes data_tvalid and data_tlast and produces frame_active and boundary. It is reused later by other frame-synchronous controllers.

Test Plan:
- Idle data stream, 28 beats of values 1..28 with tlast on beat 28:
  - wr_en 28 times at addr 0..27, bank 1.
  - load_done and coef_bank_sel = 1 two cycles after the last beat.
  - tready is 0 for exactly those 2 cycles.
- Coef frame completes while a data frame of 64 beats is at beat 10:
  - Swap on the edge of data beat 64 (tlast).
  - No bank_sel change during beats 11..63.
- Short frame, tlast on beat 5:
  - load_err one pulse; bank_sel unchanged.
  - The next full 28-beat frame loads and swaps normally.
- Long frame, 31 beats with tlast on beat 31:
  - Writes for addr 0..27 only.
  - Beats 29..31 accepted and dropped; load_err on beat 31; no swap.
- Coef tlast coincides with data tlast, then a new data frame starts immediately:
  - No swap on that edge; swap waits for the next data tlast.
- Assert reset during WAIT_SWAP after one prior swap (bank_sel = 1):
  - All outputs 0 while in reset, bank_sel = 0.
  - tready = 1 one edge after release.
